// File: rtl/ps2_kbd_rx_if.sv
// Key-event stream from the PS/2 receiver: show-ahead head entry with valid/ready.
interface ps2_kbd_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_hex_valid;
  logic [3:0] ev_hex;

  modport master (
    output ev_valid, ev_code, ev_ext, ev_break, ev_hex_valid, ev_hex,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_code, ev_ext, ev_break, ev_hex_valid, ev_hex,
    output ev_ready
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: line conditioning, 11-bit framing, E0/F0 prefix folding,
// and an event FIFO with hex-digit decode of the head entry.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_kbd_rx_if.master  ev,
  output logic          frame_err,
  output logic          overflow
);

  localparam int unsigned FCW = $clog2(FILTER_LEN);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_STOP} state_t;

  // Index 0 is the keyboard clock, index 1 the keyboard data.
  logic [1:0]          raw;
  logic [1:0]          s1_q, s2_q, filt_q;
  logic [1:0][FCW-1:0] fcnt_q;
  logic                fclk_d_q;
  logic                strobe, clk_edge, sdat;

  assign raw = {ps2_data, ps2_clk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '1;
      s2_q     <= '1;
      filt_q   <= '1;
      fcnt_q   <= '0;
      fclk_d_q <= 1'b1;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      fclk_d_q <= filt_q[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2_q[i] != filt_q[i]) begin
          if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
            filt_q[i] <= s2_q[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + 1'b1;
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end

  assign strobe   = fclk_d_q & ~filt_q[0];
  assign clk_edge = fclk_d_q ^ filt_q[0];
  assign sdat     = filt_q[1];

  state_t         state_q;
  logic [2:0]     bitcnt_q;
  logic [7:0]     sr_q;
  logic           par_q;
  logic [TCW-1:0] tcnt_q;
  logic           byte_vld_q;
  logic [7:0]     byte_q;
  logic           ext_q, brk_q;
  logic           frame_err_q;
  logic           timeout;
  logic           is_prefix;
  logic           push;
  logic [9:0]     push_word;

  assign timeout = (state_q != S_IDLE) && !clk_edge &&
                   (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));

  // Byte handling runs one cycle after the stop strobe; errors override flag updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      sr_q        <= '0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (clk_edge) begin
        tcnt_q <= '0;
      end else if ((state_q != S_IDLE) && (tcnt_q != TCW'(TIMEOUT_CYCLES))) begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      if (byte_vld_q) begin
        if (byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end

      if (timeout) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end else if (strobe) begin
        case (state_q)
          S_IDLE: begin
            if (!sdat) begin
              state_q  <= S_SHIFT;
              bitcnt_q <= '0;
            end
          end
          S_SHIFT: begin
            sr_q     <= {sdat, sr_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= sdat;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (sdat && (^{sr_q, par_q})) begin
              byte_vld_q <= 1'b1;
              byte_q     <= sr_q;
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign is_prefix = (byte_q == 8'hE0) || (byte_q == 8'hF0);
  assign push      = byte_vld_q & ~is_prefix;
  assign push_word = {ext_q, brk_q, byte_q};

  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic        empty, full, pop, do_push, ovf_d, overflow_q;
  logic [9:0]  head;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = ~empty & ev.ev_ready;
  assign do_push = push & (~full | pop);
  assign ovf_d   = push & full & ~pop;
  assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = pop ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_word;
  end

  assign head = mem_q[rd_q[AW-1:0]];

  logic       hex_ok;
  logic [3:0] hex_v;
  logic [7:0] code_o;
  logic       ext_o, brk_o;

  assign code_o = empty ? '0 : head[7:0];
  assign brk_o  = empty ? 1'b0 : head[8];
  assign ext_o  = empty ? 1'b0 : head[9];

  always_comb begin
    hex_ok = 1'b0;
    hex_v  = '0;
    if (!empty && !ext_o) begin
      hex_ok = 1'b1;
      case (code_o)
        8'h45: hex_v = 4'h0;
        8'h16: hex_v = 4'h1;
        8'h1E: hex_v = 4'h2;
        8'h26: hex_v = 4'h3;
        8'h25: hex_v = 4'h4;
        8'h2E: hex_v = 4'h5;
        8'h36: hex_v = 4'h6;
        8'h3D: hex_v = 4'h7;
        8'h3E: hex_v = 4'h8;
        8'h46: hex_v = 4'h9;
        8'h1C: hex_v = 4'hA;
        8'h32: hex_v = 4'hB;
        8'h21: hex_v = 4'hC;
        8'h23: hex_v = 4'hD;
        8'h24: hex_v = 4'hE;
        8'h2B: hex_v = 4'hF;
        default: hex_ok = 1'b0;
      endcase
    end
  end

  assign ev.ev_valid     = ~empty;
  assign ev.ev_code      = code_o;
  assign ev.ev_ext       = ext_o;
  assign ev.ev_break     = brk_o;
  assign ev.ev_hex_valid = hex_ok;
  assign ev.ev_hex       = hex_v;
  assign frame_err       = frame_err_q;
  assign overflow        = overflow_q;

endmodule
